// File: rtl/gate_result_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_result_packer_pkg
// Description : Shared defaults and width helper for gate_result_packer and
//               the code that instantiates it.
// Revision    : 1.0  initial release
// ============================================================================
package gate_result_packer_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 16;

    // Width needed to hold a count in 0..w (used for out_len / out_ones).
    function automatic int lw_of(input int w);
        return $clog2(w + 1);
    endfunction

endpackage : gate_result_packer_pkg
`default_nettype wire

// File: rtl/gate_result_packer.sv
`default_nettype none
// ============================================================================
// Module      : gate_result_packer
// Description : Samples the `gate` result bit c whenever `gate` is ready and
//               packs the samples LSB-first into WIDTH-bit words. Each word is
//               offered with its bit count and ones count over a valid/ack
//               handshake. Words completed while the output buffer is still
//               occupied are dropped and flagged by a sticky overflow bit.
// Ports       : clk, reset      clock / synchronous active-high reset
//               in_ready, in_c  sample strobe and sampled bit
//               flush           emit the partial word now
//               out_valid/ack   output handshake
//               out_data/len/ones  packed word, valid bit count, ones count
//               overflow        sticky dropped-word flag
//               word_count      acked words, wraps
// Revision    : 1.0  initial release
// ============================================================================
module gate_result_packer
    import gate_result_packer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_ready,
    input  logic                          in_c,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ack,
    output logic [WIDTH-1:0]              out_data,
    output logic [$clog2(WIDTH+1)-1:0]    out_len,
    output logic [$clog2(WIDTH+1)-1:0]    out_ones,
    output logic                          overflow,
    output logic [CNT_W-1:0]              word_count
);

    localparam int LW = $clog2(WIDTH + 1);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    // Fill-side state
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic [LW-1:0]    acc;

    // Combinational view of the word including this cycle's sample
    logic [WIDTH-1:0] sr_next;
    logic [LW-1:0]    acc_next;
    logic [LW-1:0]    len_next;
    logic             word_full;
    logic             word_flush;
    logic             word_done;
    logic             buf_free;
    logic             take;

    always_comb begin
        sr_next = sr;
        if (in_ready) begin
            sr_next[cnt] = in_c;
        end
        acc_next   = acc + LW'(in_ready & in_c);
        len_next   = LW'(cnt) + LW'(in_ready);
        word_full  = in_ready && (cnt == LAST_IDX);
        // A flush only produces a word when there is at least one bit in it,
        // counting a sample taken in the same cycle.
        word_flush = flush && ((cnt != '0) || in_ready);
        word_done  = word_full || word_flush;
        take       = out_valid && out_ack;
        buf_free   = !out_valid || out_ack;
    end

    // Fill / shift state: cleared on every completed word, delivered or not.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr  <= '0;
            cnt <= '0;
            acc <= '0;
        end else if (word_done) begin
            sr  <= '0;
            cnt <= '0;
            acc <= '0;
        end else if (in_ready) begin
            sr  <= sr_next;
            cnt <= cnt + CW'(1);
            acc <= acc_next;
        end
    end

    // Output buffer and handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_len    <= '0;
            out_ones   <= '0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            if (word_done && buf_free) begin
                // Loading in the same cycle as an ack keeps out_valid high.
                out_valid <= 1'b1;
                out_data  <= sr_next;
                out_len   <= len_next;
                out_ones  <= acc_next;
            end else if (take) begin
                out_valid <= 1'b0;
            end

            if (word_done && !buf_free) begin
                overflow <= 1'b1;
            end

            if (take) begin
                word_count <= word_count + CNT_W'(1);
            end
        end
    end

endmodule : gate_result_packer
`default_nettype wire

// File: tb/tb_gate_result_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_result_packer
// Description : Directed self-checking bench for gate_result_packer, WIDTH=4.
// Revision    : 1.0  initial release
// ============================================================================
module tb_gate_result_packer;
    import gate_result_packer_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 16;
    localparam int LW    = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             in_ready;
    logic             in_c;
    logic             flush;
    logic             out_valid;
    logic             out_ack;
    logic [WIDTH-1:0] out_data;
    logic [LW-1:0]    out_len;
    logic [LW-1:0]    out_ones;
    logic             overflow;
    logic [CNT_W-1:0] word_count;

    int checks = 0;
    int fails  = 0;

    gate_result_packer #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_ready   (in_ready),
        .in_c       (in_c),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ack    (out_ack),
        .out_data   (out_data),
        .out_len    (out_len),
        .out_ones   (out_ones),
        .overflow   (overflow),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one clock, then sample 1 time unit after the edge.
    task automatic step(input logic rdy, input logic c, input logic fl, input logic ack);
        in_ready = rdy;
        in_c     = c;
        flush    = fl;
        out_ack  = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string tag, input logic [WIDTH-1:0] d,
                            input int len, input int ones);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".data"},  32'(out_data),  32'(d));
        chk({tag, ".len"},   32'(out_len),   32'(len));
        chk({tag, ".ones"},  32'(out_ones),  32'(ones));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".valid"}, 32'(out_valid),  32'd0);
        chk({tag, ".data"},  32'(out_data),   32'd0);
        chk({tag, ".len"},   32'(out_len),    32'd0);
        chk({tag, ".ones"},  32'(out_ones),   32'd0);
        chk({tag, ".ovf"},   32'(overflow),   32'd0);
        chk({tag, ".wc"},    32'(word_count), 32'd0);
    endtask

    logic [1:0] pairs [4];

    initial begin
        reset = 1'b1; in_ready = 1'b0; in_c = 1'b0; flush = 1'b0; out_ack = 1'b1;
        @(posedge clk); #1;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk_all_zero("reset");
        reset = 1'b0;

        // 1: full word 1,0,1,1 -> 4'b1101
        step(1, 1, 0, 1); step(1, 0, 0, 1); step(1, 1, 0, 1);
        chk("t1.valid_early", 32'(out_valid), 32'd0);
        step(1, 1, 0, 1);
        chk_word("t1", 4'b1101, 4, 3);
        chk("t1.wc_before", 32'(word_count), 32'd0);
        step(0, 0, 0, 1);
        chk("t1.valid_drop", 32'(out_valid), 32'd0);
        chk("t1.wc", 32'(word_count), 32'd1);

        // 2: partial word via flush; then an empty flush does nothing
        step(1, 1, 0, 1); step(1, 1, 0, 1);
        step(0, 0, 1, 1);
        chk_word("t2", 4'b0011, 2, 2);
        step(0, 0, 0, 1);
        chk("t2.wc", 32'(word_count), 32'd2);
        step(0, 0, 1, 1);
        chk("t2.noop_valid", 32'(out_valid), 32'd0);
        step(0, 0, 0, 1);
        chk("t2.noop_valid2", 32'(out_valid), 32'd0);
        chk("t2.noop_wc", 32'(word_count), 32'd2);

        // 3: no ack, 8 samples -> first word held, second dropped
        step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
        chk_word("t3.first", 4'b1111, 4, 4);
        step(1, 0, 0, 0); step(1, 1, 0, 0);
        chk_word("t3.hold", 4'b1111, 4, 4);
        step(1, 0, 0, 0); step(1, 0, 0, 0);
        chk_word("t3.after_drop", 4'b1111, 4, 4);
        chk("t3.ovf", 32'(overflow), 32'd1);
        step(0, 0, 0, 1);
        chk("t3.valid", 32'(out_valid), 32'd0);
        chk("t3.wc", 32'(word_count), 32'd3);

        // 5: reset mid-word discards it; outputs zero during reset
        step(1, 1, 0, 1); step(1, 1, 0, 1);
        reset = 1'b1;
        step(1, 1, 0, 1);
        chk_all_zero("t5.in_reset");
        reset = 1'b0;
        step(1, 0, 0, 1); step(1, 0, 0, 1); step(1, 1, 0, 1); step(1, 0, 0, 1);
        chk_word("t5", 4'b0100, 4, 1);
        step(0, 0, 0, 1);
        chk("t5.wc", 32'(word_count), 32'd1);

        // 4: ack old word in the same cycle a new word completes
        step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
        chk_word("t4.old", 4'b0001, 4, 1);
        step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
        step(1, 0, 0, 1);
        chk_word("t4.new", 4'b0110, 4, 2);
        chk("t4.ovf", 32'(overflow), 32'd0);
        chk("t4.wc_mid", 32'(word_count), 32'd2);
        step(0, 0, 0, 1);
        chk("t4.valid", 32'(out_valid), 32'd0);
        chk("t4.wc", 32'(word_count), 32'd3);

        // 6: gate truth-table pairs (a,b) -> c = a ^ b
        pairs[0] = 2'b00; pairs[1] = 2'b01; pairs[2] = 2'b11; pairs[3] = 2'b10;
        for (int i = 0; i < 4; i++) begin
            step(1, pairs[i][1] ^ pairs[i][0], 0, 1);
        end
        chk_word("t6", 4'b1010, 4, 2);
        step(0, 0, 0, 1);

        // Flush in the same cycle as a sample includes that sample
        step(1, 1, 0, 1);
        step(1, 1, 1, 1);
        chk_word("flush_sample", 4'b0011, 2, 2);
        step(0, 0, 0, 1);
        chk("flush_sample.wc", 32'(word_count), 32'd5);
        // Ack with nothing valid is ignored
        step(0, 0, 0, 1);
        chk("idle_ack.wc", 32'(word_count), 32'd5);
        chk("final.ovf", 32'(overflow), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule : tb_gate_result_packer
`default_nettype wire
